// File: rtl/vote_collector.sv
// Four-voter ballot collector: synchronizes and debounces raw buttons, then
// latches one yes-vote per voter during a bounded voting window.
module vote_collector #(
    parameter int DEB_CYCLES = 4,
    parameter int WIN_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       close_req,
    input  logic [3:0] btn,
    output logic [3:0] votes,
    output logic       votes_valid,
    output logic       win_open
);

    typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] WIN_LOAD = 16'(WIN_CYCLES);

    logic [3:0]  sync_p0;
    logic [3:0]  sync_p1;
    logic [3:0]  deb_lvl;
    logic [3:0]  deb_rise;
    logic [7:0]  deb_cnt [4];
    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ballot;
    logic [15:0] timer;

    // stage p0 -> p1: two-flop synchronizer per button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // A rise is flagged on the same edge that flips the debounced level high
    always_comb begin
        deb_rise = '0;
        for (int i = 0; i < 4; i++) begin
            deb_rise[i] = ~deb_lvl[i] & sync_p1[i] & (deb_cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = OPEN;
            OPEN:    if (close_req || timer == 16'd1) state_nxt = DONE;
            DONE:    if (start) state_nxt = OPEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        win_open    = 1'b0;
        votes_valid = 1'b0;
        case (state)
            OPEN:    win_open    = 1'b1;
            DONE:    votes_valid = 1'b1;
            default: ;
        endcase
    end

    // Ballot and timer only change on round entry or while the window is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballot <= '0;
            timer  <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            ballot <= '0;
            timer  <= WIN_LOAD;
        end else if (state == OPEN) begin
            ballot <= ballot | deb_rise;
            if (timer != 16'd0) begin
                timer <= timer - 16'd1;
            end
        end
    end

    assign votes = ballot;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with DEB_CYCLES=4, WIN_CYCLES=32.
module tb_vote_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       close_req;
    logic [3:0] btn;
    logic [3:0] votes;
    logic       votes_valid;
    logic       win_open;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    vote_collector #(
        .DEB_CYCLES(4),
        .WIN_CYCLES(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .close_req  (close_req),
        .btn        (btn),
        .votes      (votes),
        .votes_valid(votes_valid),
        .win_open   (win_open)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_close();
        close_req = 1'b1;
        tick(1);
        close_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        close_req = 1'b0;
        btn       = 4'b0000;
        tick(2);
        chk("rst_votes", 32'(votes), 32'h0);
        chk("rst_valid", 32'(votes_valid), 32'h0);
        chk("rst_open", 32'(win_open), 32'h0);

        // Round 1: start accepted on the first edge after reset release
        rst_n = 1'b1;
        pulse_start();
        chk("r1_open", 32'(win_open), 32'h1);
        n = 0;
        while (win_open && n < 100) begin
            n++;
            if (n == 8)  btn = 4'b0101;
            if (n == 18) btn = 4'b0000;
            tick(1);
        end
        chk("r1_win_len", 32'(n), 32'd32);
        chk("r1_votes", 32'(votes), 32'h5);
        chk("r1_valid", 32'(votes_valid), 32'h1);
        tick(3);
        chk("r1_hold", 32'(votes), 32'h5);

        // Round 2: restart from DONE, then a 3-cycle glitch on btn[2]
        pulse_start();
        chk("r2_valid_fall", 32'(votes_valid), 32'h0);
        chk("r2_cleared", 32'(votes), 32'h0);
        btn = 4'b0100;
        tick(3);
        btn = 4'b0000;
        tick(10);
        chk("r2_glitch", 32'(votes), 32'h0);
        pulse_start();
        chk("r2_start_ignored", 32'(win_open), 32'h1);
        pulse_close();
        chk("r2_done", 32'(votes_valid), 32'h1);
        chk("r2_votes", 32'(votes), 32'h0);

        // Round 3: btn[0] held through the window does not count
        btn = 4'b0001;
        tick(8);
        pulse_start();
        n = 0;
        while (!votes_valid && n < 100) begin
            n++;
            tick(1);
        end
        chk("r3_timeout", 32'(n), 32'd32);
        chk("r3_held_votes", 32'(votes), 32'h0);

        // Round 4: release and repress counts; start+close in OPEN closes
        pulse_start();
        btn = 4'b0000;
        tick(8);
        btn = 4'b0001;
        tick(8);
        start     = 1'b1;
        close_req = 1'b1;
        tick(1);
        start     = 1'b0;
        close_req = 1'b0;
        chk("r4_close_wins", 32'(votes_valid), 32'h1);
        chk("r4_votes", 32'(votes), 32'h1);
        btn = 4'b0000;
        tick(8);

        // Round 5: all four pressed, close_req in the 20th open cycle
        pulse_start();
        btn = 4'b1111;
        tick(19);
        chk("r5_still_open", 32'(win_open), 32'h1);
        pulse_close();
        chk("r5_done", 32'(votes_valid), 32'h1);
        chk("r5_closed", 32'(win_open), 32'h0);
        chk("r5_votes", 32'(votes), 32'hF);
        chk("r5_timer_left", 32'(dut.timer), 32'd12);
        btn = 4'b0000;
        tick(8);

        // Round 6: reset mid-window after btn[3] is counted
        pulse_start();
        btn = 4'b1000;
        tick(7);
        chk("r6_counted", 32'(votes), 32'h8);
        chk("r6_open", 32'(win_open), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r6_async_votes", 32'(votes), 32'h0);
        chk("r6_async_open", 32'(win_open), 32'h0);
        chk("r6_async_valid", 32'(votes_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        btn   = 4'b0000;
        tick(8);
        chk("r6_idle_open", 32'(win_open), 32'h0);
        chk("r6_idle_valid", 32'(votes_valid), 32'h0);

        // Round 7: start and close_req together in IDLE opens the window
        start     = 1'b1;
        close_req = 1'b1;
        tick(1);
        start     = 1'b0;
        close_req = 1'b0;
        chk("r7_open", 32'(win_open), 32'h1);
        chk("r7_empty", 32'(votes), 32'h0);
        tick(1);
        chk("r7_stays_open", 32'(win_open), 32'h1);
        pulse_close();
        chk("r7_done", 32'(votes_valid), 32'h1);
        chk("r7_votes", 32'(votes), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
